// File: rtl/arbitro_divisor.sv
// -----------------------------------------------------------------------------
// arbitro_divisor
//   Round-robin arbiter and sequencer sharing one Divisor_Algoritmico among
//   N_REQ requesters. The granted requester's operands are latched and the
//   divider is started with a one-cycle Start pulse. Coc/Res come back with a
//   per-requester Valid pulse. A zero divisor is answered locally, because the
//   divider never terminates when Den = 0.
//
//   The divider's RSTa must be driven from ~RST. A reset mid-job abandons the
//   job: no Valid is produced, and the requester has to request again.
//
// Parameters
//   tamanyo : operand/result width, must match the divider
//   N_REQ   : number of requesters, 2..16
//
// Ports
//   CLK, RST        : clock, synchronous active-high reset
//   Req             : request level per requester
//   NumIn, DenIn    : packed operands, requester i at [i*tamanyo +: tamanyo]
//   Ack             : one-cycle pulse, that requester's operands captured
//   Valid           : one-cycle pulse, CocOut/ResOut/DivZero belong to it
//   CocOut, ResOut  : quotient / remainder, held until the next Valid
//   DivZero         : qualifies Valid, divisor was zero
//   Busy            : high whenever a job is in progress
//   DivStart        : to divider Start
//   DivNum, DivDen  : to divider Num / Den
//   DivCoc, DivRes  : from divider Coc / Res
//   DivDone         : from divider Done
// -----------------------------------------------------------------------------
module arbitro_divisor #(
  parameter int tamanyo = 32,
  parameter int N_REQ   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*tamanyo-1:0]   NumIn,
  input  logic [N_REQ*tamanyo-1:0]   DenIn,
  output logic [N_REQ-1:0]           Ack,
  output logic [N_REQ-1:0]           Valid,
  output logic [tamanyo-1:0]         CocOut,
  output logic [tamanyo-1:0]         ResOut,
  output logic                       DivZero,
  output logic                       Busy,
  output logic                       DivStart,
  output logic [tamanyo-1:0]         DivNum,
  output logic [tamanyo-1:0]         DivDen,
  input  logic [tamanyo-1:0]         DivCoc,
  input  logic [tamanyo-1:0]         DivRes,
  input  logic                       DivDone
);

  localparam int PW  = $clog2(N_REQ);
  localparam int PW1 = PW + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ZERO  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;
  logic [PW-1:0]      r_gnt;
  logic [PW-1:0]      w_gnt_nxt;
  logic [PW-1:0]      w_pick;
  logic [PW-1:0]      w_gnt_inc;
  logic               w_any_req;
  logic [tamanyo-1:0] w_sel_num;
  logic [tamanyo-1:0] w_sel_den;
  logic [tamanyo-1:0] w_num_arr [N_REQ];
  logic [tamanyo-1:0] w_den_arr [N_REQ];

  logic [N_REQ-1:0]   w_ack_nxt;
  logic [N_REQ-1:0]   w_valid_nxt;
  logic [tamanyo-1:0] w_coc_nxt;
  logic [tamanyo-1:0] w_res_nxt;
  logic [tamanyo-1:0] w_num_nxt;
  logic [tamanyo-1:0] w_den_nxt;
  logic               w_dz_nxt;
  logic               w_start_nxt;
  logic               w_busy_nxt;

  // First requesting index at or after ptr, wrapping; ptr itself if none.
  function automatic logic [PW-1:0] f_rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [PW-1:0]    ptr
  );
    logic [PW-1:0]  pick;
    logic           found;
    logic [PW1-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + PW1'(k);
      if (idx >= PW1'(N_REQ)) begin
        idx = idx - PW1'(N_REQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_num_arr[gi] = NumIn[gi*tamanyo +: tamanyo];
    assign w_den_arr[gi] = DenIn[gi*tamanyo +: tamanyo];
  end

  assign w_any_req = |Req;
  assign w_pick    = f_rr_pick(Req, r_ptr);
  assign w_sel_num = w_num_arr[w_pick];
  assign w_sel_den = w_den_arr[w_pick];
  assign w_gnt_inc = (r_gnt == PW'(N_REQ - 1)) ? '0 : r_gnt + PW'(1);

  // Next-state and next-output logic; held registers default to their value.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_valid_nxt = '0;
    w_start_nxt = 1'b0;
    w_num_nxt   = DivNum;
    w_den_nxt   = DivDen;
    w_coc_nxt   = CocOut;
    w_res_nxt   = ResOut;
    w_dz_nxt    = DivZero;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt = w_pick;
          w_num_nxt = w_sel_num;
          w_den_nxt = w_sel_den;
          w_ack_nxt = N_REQ'(1) << w_pick;
          // Start is registered, so it is raised here to be high during ISSUE.
          if (w_sel_den == {tamanyo{1'b0}}) begin
            w_state_nxt = ST_ZERO;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_start_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (DivDone) begin
          w_coc_nxt   = DivCoc;
          w_res_nxt   = DivRes;
          w_dz_nxt    = 1'b0;
          w_valid_nxt = N_REQ'(1) << r_gnt;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ZERO: begin
        w_coc_nxt   = {tamanyo{1'b1}};
        w_res_nxt   = DivNum;
        w_dz_nxt    = 1'b1;
        w_valid_nxt = N_REQ'(1) << r_gnt;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_ptr_nxt   = w_gnt_inc;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, pointer and output registers; RST overrides every transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      Ack      <= '0;
      Valid    <= '0;
      DivStart <= 1'b0;
      Busy     <= 1'b0;
      DivZero  <= 1'b0;
      CocOut   <= '0;
      ResOut   <= '0;
      DivNum   <= '0;
      DivDen   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      Ack      <= w_ack_nxt;
      Valid    <= w_valid_nxt;
      DivStart <= w_start_nxt;
      Busy     <= w_busy_nxt;
      DivZero  <= w_dz_nxt;
      CocOut   <= w_coc_nxt;
      ResOut   <= w_res_nxt;
      DivNum   <= w_num_nxt;
      DivDen   <= w_den_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_divisor.sv
// -----------------------------------------------------------------------------
// tb_arbitro_divisor
//   Bench for arbitro_divisor with a behavioural divider, a job-level
//   reference model checking every output each cycle, directed scenarios and
//   a randomized phase with random requests, latencies and resets.
// -----------------------------------------------------------------------------
module tb_arbitro_divisor;

  localparam int TW = 32;
  localparam int NR = 4;

  logic              CLK;
  logic              RST;
  logic [NR-1:0]     Req;
  logic [NR*TW-1:0]  NumIn;
  logic [NR*TW-1:0]  DenIn;
  logic [NR-1:0]     Ack;
  logic [NR-1:0]     Valid;
  logic [TW-1:0]     CocOut;
  logic [TW-1:0]     ResOut;
  logic              DivZero;
  logic              Busy;
  logic              DivStart;
  logic [TW-1:0]     DivNum;
  logic [TW-1:0]     DivDen;
  logic [TW-1:0]     DivCoc;
  logic [TW-1:0]     DivRes;
  logic              DivDone;

  arbitro_divisor #(.tamanyo(TW), .N_REQ(NR)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Req      (Req),
    .NumIn    (NumIn),
    .DenIn    (DenIn),
    .Ack      (Ack),
    .Valid    (Valid),
    .CocOut   (CocOut),
    .ResOut   (ResOut),
    .DivZero  (DivZero),
    .Busy     (Busy),
    .DivStart (DivStart),
    .DivNum   (DivNum),
    .DivDen   (DivDen),
    .DivCoc   (DivCoc),
    .DivRes   (DivRes),
    .DivDone  (DivDone)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;
  int div_lat  = 5;
  bit rand_lat = 1'b0;
  int order[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] rnd_den();
    int unsigned s;
    s = $urandom_range(7, 0);
    if (s == 0) return '0;
    else if (s < 4) return TW'($urandom_range(15, 1));
    else return $urandom;
  endfunction

  // Behavioural divider: Done is sampled div_lat edges after Start; while
  // idle it throws spurious Done pulses with garbage that must be ignored.
  initial begin : divider_model
    logic          st;
    logic          rs;
    logic [TW-1:0] sn;
    logic [TW-1:0] sd;
    logic [TW-1:0] an;
    logic [TW-1:0] ad;
    bit            act;
    int            cnt;
    act = 1'b0; cnt = 0; an = '0; ad = '0;
    DivDone = 1'b0; DivCoc = '0; DivRes = '0;
    forever begin
      @(posedge CLK);
      st = DivStart; rs = RST; sn = DivNum; sd = DivDen;
      #1;
      DivDone = 1'b0;
      if (rs === 1'b1) begin
        act = 1'b0;
      end else if (st === 1'b1) begin
        act = 1'b1; an = sn; ad = sd;
        cnt = rand_lat ? int'($urandom_range(8, 2)) : div_lat;
      end
      if (act) begin
        cnt--;
        if (cnt <= 0 && ad != '0) begin
          DivDone = 1'b1; DivCoc = an / ad; DivRes = an % ad; act = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        DivDone = 1'b1; DivCoc = $urandom; DivRes = $urandom;
      end
    end
  end

  // Reference model: at each edge decide from the sampled inputs what the
  // outputs must be afterwards, then compare on the falling edge.
  initial begin : monitor
    logic          rs;
    logic [NR-1:0] q;
    logic          dn;
    logic [NR*TW-1:0] ni;
    logic [NR*TW-1:0] di;
    bit            seen_rst;
    bit            m_busy;
    bit            m_res;
    int            m_g;
    int            m_ptr;
    int            m_edges;
    int            g;
    int            idx;
    logic [TW-1:0] m_num;
    logic [TW-1:0] m_den;
    logic [NR-1:0] e_ack;
    logic [NR-1:0] e_valid;
    logic          e_busy;
    logic          e_start;
    logic          e_dz;
    logic [TW-1:0] e_num;
    logic [TW-1:0] e_den;
    logic [TW-1:0] e_coc;
    logic [TW-1:0] e_res;
    seen_rst = 1'b0; m_busy = 1'b0; m_res = 1'b0; m_g = 0; m_ptr = 0; m_edges = 0;
    m_num = '0; m_den = '0;
    e_ack = '0; e_valid = '0; e_busy = 1'b0; e_start = 1'b0; e_dz = 1'b0;
    e_num = '0; e_den = '0; e_coc = '0; e_res = '0;
    forever begin
      @(posedge CLK);
      rs = RST; q = Req; dn = DivDone; ni = NumIn; di = DenIn;
      e_ack = '0; e_valid = '0; e_start = 1'b0;
      if (rs === 1'b1) begin
        seen_rst = 1'b1; m_busy = 1'b0; m_ptr = 0;
        e_num = '0; e_den = '0; e_coc = '0; e_res = '0; e_dz = 1'b0;
      end else if (!m_busy) begin
        if (q != '0) begin
          g = -1;
          for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && q[idx]) g = idx;
          end
          m_busy = 1'b1; m_g = g; m_edges = 0; m_res = 1'b0;
          m_num = ni[g*TW +: TW]; m_den = di[g*TW +: TW];
          e_ack[g] = 1'b1; e_num = m_num; e_den = m_den;
          e_start = (m_den != '0);
        end
      end else begin
        m_edges++;
        if (m_res) begin
          m_ptr = (m_g + 1) % NR; m_busy = 1'b0;
        end else if (m_den == '0) begin
          e_coc = '1; e_res = m_num; e_dz = 1'b1; e_valid[m_g] = 1'b1; m_res = 1'b1;
        end else if (m_edges >= 2 && dn === 1'b1) begin
          e_coc = m_num / m_den; e_res = m_num % m_den; e_dz = 1'b0;
          e_valid[m_g] = 1'b1; m_res = 1'b1;
        end
      end
      e_busy = m_busy;
      @(negedge CLK);
      if (seen_rst) begin
        check_val("ack", Ack, e_ack);
        check_val("valid", Valid, e_valid);
        check_val("busy", Busy, e_busy);
        check_val("divstart", DivStart, e_start);
        check_val("divnum", DivNum, e_num);
        check_val("divden", DivDen, e_den);
        check_val("divzero", DivZero, e_dz);
        check_val("cocout", CocOut, e_coc);
        check_val("resout", ResOut, e_res);
      end
    end
  end

  task automatic run_job(input int i, input logic [TW-1:0] n, input logic [TW-1:0] d,
                         input int lat, output int starts, output int cyc);
    bit ok;
    ok = 1'b0; starts = 0; cyc = 0;
    div_lat = lat;
    @(negedge CLK);
    Req[i] = 1'b1; NumIn[i*TW +: TW] = n; DenIn[i*TW +: TW] = d;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge CLK);
      if (Ack[i]) ok = 1'b1;
    end
    check_val("job_ack_seen", ok, 1);
    Req[i] = 1'b0; NumIn[i*TW +: TW] = $urandom; DenIn[i*TW +: TW] = $urandom;
    if (DivStart) starts++;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge CLK);
      cyc++;
      if (DivStart) starts++;
      if (Valid[i]) ok = 1'b1;
    end
    check_val("job_valid_seen", ok, 1);
  endtask

  task automatic collect_grants(input int n);
    order.delete();
    for (int c = 0; c < 600 && order.size() < n; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NR; i++) begin
        if (Ack[i]) begin
          order.push_back(i);
          if (order.size() >= n) Req = '0;
          else Req[i] = 1'b0;
        end
      end
    end
    check_val("grant_count", order.size(), n);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge CLK);
      if (!Busy) ok = 1'b1;
    end
    check_val("idle_reached", ok, 1);
    @(negedge CLK);
  endtask

  initial begin : main
    int st;
    int cy;
    int vcnt;
    RST = 1'b1; Req = '0; NumIn = '0; DenIn = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Single request
    run_job(0, 32'd100, 32'd7, 5, st, cy);
    check_val("t1_coc", CocOut, 32'd14);
    check_val("t1_res", ResOut, 32'd2);
    check_val("t1_dz", DivZero, 1'b0);
    check_val("t1_starts", st, 1);
    check_val("t1_latency", cy, 6);

    // Division by zero
    run_job(2, 32'd55, 32'd0, 5, st, cy);
    check_val("t2_coc", CocOut, 32'hFFFF_FFFF);
    check_val("t2_res", ResOut, 32'd55);
    check_val("t2_dz", DivZero, 1'b1);
    check_val("t2_starts", st, 0);
    check_val("t2_latency", cy, 1);

    // Fairness from ptr = 0 with all requesters held high
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    div_lat = 3;
    for (int i = 0; i < NR; i++) begin
      NumIn[i*TW +: TW] = 1000 * (i + 1) + 7 * i;
      DenIn[i*TW +: TW] = i + 3;
    end
    Req = '1;
    order.delete();
    for (int c = 0; c < 400 && order.size() < 5; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NR; i++) if (Ack[i]) order.push_back(i);
    end
    Req = '0;
    check_val("t3_count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) check_val("t3_order", order[k], k % NR);
    wait_idle();

    // Pointer rotation: after a job on 1, ptr is 2, so 3 beats 1
    run_job(1, 32'd77, 32'd5, 2, st, cy);
    @(negedge CLK);
    Req[3] = 1'b1; NumIn[3*TW +: TW] = 32'd300; DenIn[3*TW +: TW] = 32'd7;
    Req[1] = 1'b1; NumIn[1*TW +: TW] = 32'd91;  DenIn[1*TW +: TW] = 32'd4;
    collect_grants(2);
    if (order.size() == 2) begin
      check_val("t4_first", order[0], 3);
      check_val("t4_second", order[1], 1);
    end
    wait_idle();

    // Reset in the middle of a long job
    div_lat = 50;
    @(negedge CLK);
    Req[1] = 1'b1; NumIn[1*TW +: TW] = 32'd500; DenIn[1*TW +: TW] = 32'd9;
    collect_grants(1);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_val("t5_busy", Busy, 1'b0);
    check_val("t5_divnum", DivNum, '0);
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (Valid != '0) vcnt++;
    end
    check_val("t5_no_valid", vcnt, 0);
    div_lat = 4;
    Req[1] = 1'b1; NumIn[1*TW +: TW] = 32'd500; DenIn[1*TW +: TW] = 32'd9;
    Req[3] = 1'b1; NumIn[3*TW +: TW] = 32'd42;  DenIn[3*TW +: TW] = 32'd0;
    collect_grants(2);
    if (order.size() == 2) begin
      check_val("t5_first", order[0], 1);
      check_val("t5_second", order[1], 3);
    end
    wait_idle();

    // Late Done and operand stability after Ack
    run_job(0, 32'd1000, 32'd3, 200, st, cy);
    check_val("t6_latency", cy, 201);
    check_val("t6_coc", CocOut, 32'd333);
    check_val("t6_res", ResOut, 32'd1);
    wait_idle();

    // Randomized traffic with occasional resets
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST = ($urandom_range(299, 0) == 0);
      for (int i = 0; i < NR; i++) begin
        if (Ack[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            NumIn[i*TW +: TW] = $urandom; DenIn[i*TW +: TW] = rnd_den();
          end else begin
            Req[i] = 1'b0; NumIn[i*TW +: TW] = $urandom; DenIn[i*TW +: TW] = $urandom;
          end
        end else if (!Req[i] && $urandom_range(3, 0) == 0) begin
          Req[i] = 1'b1; NumIn[i*TW +: TW] = $urandom; DenIn[i*TW +: TW] = rnd_den();
        end
      end
    end
    @(negedge CLK);
    RST = 1'b0; Req = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
